// File: rtl/tl_a_burst_repeater.sv
// TileLink A-channel burst repeater: passes a request through, then replays it N times.
// Optional replay statistics counter enabled by TL_REPEATER_STATS_EN.
module tl_a_burst_repeater #(
  parameter int ADDR_W = 12,
  parameter int SRC_W  = 6,
  parameter int MASK_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [2:0]        enq_opcode,
  input  logic [2:0]        enq_param,
  input  logic [2:0]        enq_size,
  input  logic [SRC_W-1:0]  enq_source,
  input  logic [ADDR_W-1:0] enq_address,
  input  logic [MASK_W-1:0] enq_mask,
  input  logic              enq_corrupt,
  input  logic [CNT_W-1:0]  enq_count,
  input  logic              enq_incr,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [2:0]        deq_opcode,
  output logic [2:0]        deq_param,
  output logic [2:0]        deq_size,
  output logic [SRC_W-1:0]  deq_source,
  output logic [ADDR_W-1:0] deq_address,
  output logic [MASK_W-1:0] deq_mask,
  output logic              deq_corrupt,
  output logic              busy,
  output logic [CNT_W-1:0]  remaining,
  output logic [31:0]       stat_replays
);

  typedef enum logic {IDLE, REPLAY} state_e;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(MASK_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cap;
  logic [2:0]        opcode_q, param_q, size_q;
  logic [SRC_W-1:0]  source_q;
  logic [MASK_W-1:0] mask_q;
  logic              corrupt_q, incr_q;
  logic              enq_fire;

  assign busy      = (state_q == REPLAY);
  assign remaining = rem_q;
  assign enq_ready = deq_ready & ~busy;
  assign deq_valid = enq_valid | busy;
  assign enq_fire  = enq_valid & enq_ready;

  assign deq_opcode  = busy ? opcode_q  : enq_opcode;
  assign deq_param   = busy ? param_q   : enq_param;
  assign deq_size    = busy ? size_q    : enq_size;
  assign deq_source  = busy ? source_q  : enq_source;
  assign deq_address = busy ? addr_q    : enq_address;
  assign deq_mask    = busy ? mask_q    : enq_mask;
  assign deq_corrupt = busy ? corrupt_q : enq_corrupt;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enq_fire && (enq_count != '0)) begin
          state_d = REPLAY;
          rem_d   = enq_count;
          cap     = 1'b1;
          addr_d  = enq_incr ? enq_address + STEP
                             : enq_address;
        end
      end
      REPLAY: begin
        if (deq_ready) begin
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - CNT_W'(1);
            if (incr_q) addr_d = addr_q + STEP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Payload registers carry no reset; busy gates their visibility.
  always_ff @(posedge clock) begin
    addr_q <= addr_d;
    if (cap) begin
      opcode_q  <= enq_opcode;
      param_q   <= enq_param;
      size_q    <= enq_size;
      source_q  <= enq_source;
      mask_q    <= enq_mask;
      corrupt_q <= enq_corrupt;
      incr_q    <= enq_incr;
    end
  end

`ifdef TL_REPEATER_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_q <= '0;
    end else if (busy && deq_ready && (stat_q != '1)) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_replays = stat_q;
`else
  assign stat_replays = 32'd0;
`endif

endmodule

// File: tb/tb_tl_a_burst_repeater.sv
// Directed bench for tl_a_burst_repeater: pass-through, bursts,
// backpressure, address wrap, reset mid-replay and stats.
module tb_tl_a_burst_repeater;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid, enq_ready;
  logic [2:0]  enq_opcode, enq_param, enq_size;
  logic [5:0]  enq_source;
  logic [11:0] enq_address;
  logic [7:0]  enq_mask;
  logic        enq_corrupt;
  logic [3:0]  enq_count;
  logic        enq_incr;
  logic        deq_valid, deq_ready;
  logic [2:0]  deq_opcode, deq_param, deq_size;
  logic [5:0]  deq_source;
  logic [11:0] deq_address;
  logic [7:0]  deq_mask;
  logic        deq_corrupt;
  logic        busy;
  logic [3:0]  remaining;
  logic [31:0] stat_replays;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tl_a_burst_repeater dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_opcode(enq_opcode), .enq_param(enq_param),
    .enq_size(enq_size), .enq_source(enq_source),
    .enq_address(enq_address), .enq_mask(enq_mask),
    .enq_corrupt(enq_corrupt), .enq_count(enq_count),
    .enq_incr(enq_incr),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_opcode(deq_opcode), .deq_param(deq_param),
    .deq_size(deq_size), .deq_source(deq_source),
    .deq_address(deq_address), .deq_mask(deq_mask),
    .deq_corrupt(deq_corrupt),
    .busy(busy), .remaining(remaining),
    .stat_replays(stat_replays)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(input logic [11:0] a,
                       input logic [3:0] n,
                       input logic inc);
    enq_valid   = 1'b1;
    enq_address = a;
    enq_count   = n;
    enq_incr    = inc;
  endtask

  // Sends one request and drains it with deq_ready held high.
  task automatic burst(input logic [11:0] a,
                       input logic [3:0] n);
    @(negedge clock);
    deq_ready = 1'b1;
    drive(a, n, 1'b1);
    @(posedge clock);
    @(negedge clock);
    enq_valid = 1'b0;
    for (int i = 0; i < int'(n); i++) @(posedge clock);
  endtask

  initial begin
    reset       = 1'b1;
    enq_valid   = 1'b0;
    enq_opcode  = 3'd4;
    enq_param   = 3'd0;
    enq_size    = 3'd3;
    enq_source  = 6'd5;
    enq_address = '0;
    enq_mask    = 8'hFF;
    enq_corrupt = 1'b0;
    enq_count   = '0;
    enq_incr    = 1'b0;
    deq_ready   = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    chk("rst_stat", stat_replays, 32'd0);
    chk("rst_dvalid", 32'(deq_valid), 32'd0);
    chk("rst_eready", 32'(enq_ready), 32'd1);

    // Pass-through with count 0
    @(negedge clock);
    drive(12'h100, 4'd0, 1'b0);
    #1;
    chk("pt_dvalid", 32'(deq_valid), 32'd1);
    chk("pt_addr", 32'(deq_address), 32'h100);
    chk("pt_src", 32'(deq_source), 32'd5);
    @(posedge clock);
    @(negedge clock);
    enq_valid = 1'b0;
    #1;
    chk("pt_busy", 32'(busy), 32'd0);
    chk("pt_dvalid0", 32'(deq_valid), 32'd0);

    // Incrementing burst, count 3
    @(negedge clock);
    drive(12'h040, 4'd3, 1'b1);
    #1;
    chk("inc_addr0", 32'(deq_address), 32'h040);
    chk("inc_eready0", 32'(enq_ready), 32'd1);
    @(posedge clock);
    @(negedge clock);
    // a competing request stays pending and must be ignored
    drive(12'h300, 4'd0, 1'b0);
    enq_source = 6'd9;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("inc_busy", 32'(busy), 32'd1);
      chk("inc_eready", 32'(enq_ready), 32'd0);
      chk("inc_rem", 32'(remaining), 32'(4 - k));
      chk("inc_addr", 32'(deq_address), 32'h040 + 32'(8 * k));
      chk("inc_src", 32'(deq_source), 32'd5);
      @(posedge clock);
      @(negedge clock);
    end
    enq_valid  = 1'b0;
    enq_source = 6'd5;
    #1;
    chk("inc_done_busy", 32'(busy), 32'd0);
    chk("inc_done_rem", 32'(remaining), 32'd0);
    chk("inc_done_dv", 32'(deq_valid), 32'd0);

    // Fixed repeat with backpressure, count 2
    @(negedge clock);
    drive(12'h200, 4'd2, 1'b0);
    @(posedge clock);
    for (int k = 2; k >= 1; k--) begin
      @(negedge clock);
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      #1;
      chk("fix_stall_rem", 32'(remaining), 32'(k));
      chk("fix_stall_dv", 32'(deq_valid), 32'd1);
      @(posedge clock);
      @(negedge clock);
      deq_ready = 1'b1;
      #1;
      chk("fix_hold_rem", 32'(remaining), 32'(k));
      chk("fix_hold_addr", 32'(deq_address), 32'h200);
      chk("fix_hold_mask", 32'(deq_mask), 32'hFF);
      @(posedge clock);
    end
    @(negedge clock);
    #1;
    chk("fix_done_busy", 32'(busy), 32'd0);
    chk("fix_done_rem", 32'(remaining), 32'd0);

    // Address wrap
    @(negedge clock);
    drive(12'hFF8, 4'd1, 1'b1);
    #1;
    chk("wrap_addr0", 32'(deq_address), 32'hFF8);
    @(posedge clock);
    @(negedge clock);
    enq_valid = 1'b0;
    #1;
    chk("wrap_addr1", 32'(deq_address), 32'h000);
    chk("wrap_rem", 32'(remaining), 32'd1);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("wrap_busy", 32'(busy), 32'd0);

    // Reset mid-replay after two beats
    @(negedge clock);
    drive(12'h080, 4'd5, 1'b1);
    @(posedge clock);
    @(negedge clock);
    enq_valid = 1'b0;
    #1;
    chk("mid_rem5", 32'(remaining), 32'd5);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rem", 32'(remaining), 32'd0);
    chk("mid_dvalid", 32'(deq_valid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("mid_dvalid2", 32'(deq_valid), 32'd0);

    // Stats over bursts of 3 and 2 replays
    burst(12'h010, 4'd3);
    burst(12'h020, 4'd2);
    @(negedge clock);
    #1;
    chk("stats_busy", 32'(busy), 32'd0);
`ifdef TL_REPEATER_STATS_EN
    chk("stats", stat_replays, 32'd5);
`else
    chk("stats", stat_replays, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
